// File: rtl/kgp_pkg.sv
// Shared widths, ALU op encodings and operand-stage state type for the
// register-read / ALU slice.
package kgp_pkg;

    localparam int KGP_DATA_W = 32;
    localparam int KGP_ADDR_W = 5;
    localparam int KGP_OP_W   = 3;

    typedef enum logic [KGP_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_t;

    // The output register is either empty or holding one operand set.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } of_state_t;

endpackage

// File: rtl/gpr_file.sv
// General-purpose register array: two asynchronous read ports and one
// synchronous write port. Synchronous reset clears every entry.
module gpr_file
    import kgp_pkg::*;
#(
    parameter int DATA_W = KGP_DATA_W,
    parameter int ADDR_W = KGP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  wr_sel;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    // The reset clears the whole array, so it cannot map to block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                regs_reg[i] <= wr_data;
            end
        end
    end

    assign rd0_data = regs_reg[rd0_addr];
    assign rd1_data = regs_reg[rd1_addr];

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage ahead of the ALU: GPR file, one-entry output register
// and valid/ready handshake. Define RF_BYPASS_EN for writeback bypassing.
module operand_fetch
    import kgp_pkg::*;
#(
    parameter int DATA_W = KGP_DATA_W,
    parameter int ADDR_W = KGP_ADDR_W,
    parameter int OP_W   = KGP_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [OP_W-1:0]   op_in,
    input  logic [4:0]        sh_amt_in,
    input  logic              shift_src_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [4:0]        sh_amt,
    output logic              shift_src,
    output logic [OP_W-1:0]   op
);

    of_state_t         state_reg, state_next;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [4:0]        sh_amt_reg;
    logic              shift_src_reg;
    logic [OP_W-1:0]   op_reg;
    logic              accept;

    gpr_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gpr_file (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd0_addr (rs_addr),
        .rd0_data (rf_a),
        .rd1_addr (rt_addr),
        .rd1_data (rf_b)
    );

    assign in_ready = (state_reg == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef RF_BYPASS_EN
    logic [ADDR_W-1:0] rs_held_reg, rt_held_reg;
    logic              hold;

    assign rd_a = (wr_en && wr_addr == rs_addr) ? wr_data : rf_a;
    assign rd_b = (wr_en && wr_addr == rt_addr) ? wr_data : rf_b;
    assign hold = (state_reg == ST_FULL) && !out_ready;
`else
    assign rd_a = rf_a;
    assign rd_b = rf_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sh_amt_reg    <= '0;
            shift_src_reg <= 1'b0;
            op_reg        <= '0;
`ifdef RF_BYPASS_EN
            rs_held_reg   <= '0;
            rt_held_reg   <= '0;
`endif
        end else if (accept) begin
            a_reg         <= rd_a;
            b_reg         <= rd_b;
            sh_amt_reg    <= sh_amt_in;
            shift_src_reg <= shift_src_in;
            op_reg        <= op_in;
`ifdef RF_BYPASS_EN
            rs_held_reg   <= rs_addr;
            rt_held_reg   <= rt_addr;
        end else if (hold && wr_en) begin
            // A stalled operand tracks writeback to its source register.
            if (wr_addr == rs_held_reg) a_reg <= wr_data;
            if (wr_addr == rt_held_reg) b_reg <= wr_data;
`endif
        end
    end

    assign out_valid = (state_reg == ST_FULL);
    assign a         = a_reg;
    assign b         = b_reg;
    assign sh_amt    = sh_amt_reg;
    assign shift_src = shift_src_reg;
    assign op        = op_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch; expectations follow RF_BYPASS_EN.
`timescale 1ns/1ps
module tb_operand_fetch;
    import kgp_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr, rt_addr;
    logic [2:0]  op_in;
    logic [4:0]  sh_amt_in;
    logic        shift_src_in;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic [4:0]  sh_amt;
    logic        shift_src;
    logic [2:0]  op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .op_in        (op_in),
        .sh_amt_in    (sh_amt_in),
        .shift_src_in (shift_src_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a            (a),
        .b            (b),
        .sh_amt       (sh_amt),
        .shift_src    (shift_src),
        .op           (op)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] o,
                         input logic [4:0] sa, input logic ss);
        in_valid = 1'b1; rs_addr = rs; rt_addr = rt; op_in = o; sh_amt_in = sa; shift_src_in = ss;
        $display("issue rs=%0d rt=%0d op=%0d sh_amt=%0d shift_src=%0d", rs, rt, o, sa, ss);
    endtask

    task automatic write(input logic [4:0] ad, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = ad; wr_data = d;
        $display("write r%0d=%h", ad, d);
    endtask

    task automatic idle();
        in_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); out_ready = 1'b1;
        rs_addr = '0; rt_addr = '0; op_in = '0; sh_amt_in = '0; shift_src_in = 1'b0;
        wr_addr = '0; wr_data = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (a !== 32'h0 || b !== 32'h0) begin errors++; $display("FAIL reset_ab got a=%h b=%h want 0 0", a, b); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        rst = 1'b0;
        issue(5, 6, 3'd0, 5'd0, 1'b0);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL first_issue got v=%0b a=%h b=%h want 1 0 0", out_valid, a, b); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_write_read();
        write(3, 32'hFFFF_FFCA); tick();
        write(4, 32'h0000_0036); tick();
        idle();
        issue(3, 4, 3'(ALU_SUB), 5'd5, 1'b1);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %0b want 1", out_valid); end
        checks++; if (a !== 32'hFFFF_FFCA) begin errors++; $display("FAIL rd_a got %h want ffffffca", a); end
        checks++; if (b !== 32'h0000_0036) begin errors++; $display("FAIL rd_b got %h want 00000036", b); end
        checks++; if (op !== 3'd1 || sh_amt !== 5'd5 || shift_src !== 1'b1) begin
            errors++; $display("FAIL rd_fields got op=%0d sa=%0d ss=%0b want 1 5 1", op, sh_amt, shift_src); end
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        issue(4, 3, 3'd3, 5'd7, 1'b0);
        tick();
        issue(3, 4, 3'd2, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0b want 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || a !== 32'h36 || b !== 32'hFFFF_FFCA || op !== 3'd3 || sh_amt !== 5'd7) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%0b a=%h b=%h op=%0d sa=%0d want 1 36 ffffffca 3 7",
                                   i, out_valid, a, b, op, sh_amt); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || a !== 32'hFFFF_FFCA || b !== 32'h36 || op !== 3'd2 || shift_src !== 1'b1) begin
            errors++; $display("FAIL back_to_back got v=%0b a=%h b=%h op=%0d ss=%0b want 1 ffffffca 36 2 1",
                               out_valid, a, b, op, shift_src); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_bypass_accept();
        logic [31:0] exp_a;
        exp_a = BYPASS ? 32'h55 : 32'h0;
        write(7, 32'h55);
        issue(7, 4, 3'd0, 5'd0, 1'b0);
        tick();
        idle();
        checks++; if (a !== exp_a || b !== 32'h36) begin
            errors++; $display("FAIL same_cycle_read got a=%h b=%h want %h 36", a, b, exp_a); end
        tick();
        issue(7, 7, 3'd0, 5'd0, 1'b0);
        tick();
        idle();
        checks++; if (a !== 32'h55 || b !== 32'h55) begin
            errors++; $display("FAIL r7_written got a=%h b=%h want 55 55", a, b); end
        tick();
    endtask

    task automatic test_bypass_hold();
        logic [31:0] exp_v;
        exp_v = BYPASS ? 32'h1 : 32'hFFFF_FFCA;
        out_ready = 1'b0;
        issue(3, 3, 3'd4, 5'd1, 1'b0);
        tick();
        idle();
        checks++; if (a !== 32'hFFFF_FFCA || b !== 32'hFFFF_FFCA) begin
            errors++; $display("FAIL hold_load got a=%h b=%h want ffffffca ffffffca", a, b); end
        write(3, 32'h1);
        tick();
        idle();
        checks++; if (a !== exp_v || b !== exp_v) begin
            errors++; $display("FAIL hold_update got a=%h b=%h want %h %h", a, b, exp_v, exp_v); end
        write(4, 32'hDEAD_BEEF);
        tick();
        idle();
        checks++; if (a !== exp_v || b !== exp_v || out_valid !== 1'b1) begin
            errors++; $display("FAIL hold_other_addr got a=%h b=%h v=%0b want %h %h 1", a, b, out_valid, exp_v, exp_v); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_full();
        write(9, 32'h99); tick();
        idle();
        out_ready = 1'b0;
        issue(9, 4, 3'd5, 5'd3, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b1 || a !== 32'h99) begin
            errors++; $display("FAIL pre_reset_full got v=%0b a=%h want 1 99", out_valid, a); end
        rst = 1'b1;
        write(10, 32'hAB);
        tick();
        rst = 1'b0;
        idle();
        checks++; if (out_valid !== 1'b0 || a !== 32'h0 || b !== 32'h0 || op !== 3'd0 || sh_amt !== 5'd0 || shift_src !== 1'b0) begin
            errors++; $display("FAIL reset_full got v=%0b a=%h b=%h op=%0d sa=%0d ss=%0b want all 0",
                               out_valid, a, b, op, sh_amt, shift_src); end
        out_ready = 1'b1;
        issue(9, 10, 3'd0, 5'd0, 1'b0);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL reset_cleared_rf got v=%0b a=%h b=%h want 1 0 0", out_valid, a, b); end
        issue(3, 7, 3'd0, 5'd0, 1'b0);
        tick();
        idle();
        checks++; if (a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL reset_cleared_r3_r7 got a=%h b=%h want 0 0", a, b); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stall();
        test_bypass_accept();
        test_bypass_hold();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
